// File: rtl/spike_counter_bank.sv
// spike_counter_bank
//   Counts rising edges on NCH spike lines in parallel. On each simulation
//   tick the per-channel counts are latched into snapshot registers. The
//   snapshots are served through a registered read port.
//
// Ports
//   clk        sole clock
//   reset      asynchronous, active-low; clears all state
//   en         count enable; ticks still snapshot while low
//   mode       0 = windowed (live cleared at tick), 1 = cumulative
//   tick       one-cycle end-of-step strobe
//   clear      synchronous clear of live counters, snapshots and ovf
//   spike_in   raw spike levels, one per channel
//   rd_sel     snapshot channel to read (>= NCH reads 0)
//   rd_data    registered snapshot of channel rd_sel
//   snap_valid one-cycle pulse: new snapshots visible
//   ovf        sticky per-channel overflow flags

// Per-channel edge detector, live counter and snapshot register.
module spike_counter_lane #(
    parameter int CNT_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             tick,
    input  logic             clear,
    input  logic             spike,
    output logic [CNT_W-1:0] snap,
    output logic             ovf
);
    logic             spike_prev;
    logic [CNT_W-1:0] live;
    logic             spk_edge;
    logic             ovf_hit;
    logic [CNT_W-1:0] sum;

    // sum serves both the live update and the snapshot, so a spike landing
    // on the tick cycle is counted exactly once (into the closing window).
    always_comb begin
        spk_edge = spike & ~spike_prev & en;
        ovf_hit  = spk_edge & (&live);
        if (ovf_hit)
            sum = SAT ? live : '0;
        else
            sum = live + CNT_W'(spk_edge);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_prev <= 1'b0;
            live       <= '0;
            snap       <= '0;
            ovf        <= 1'b0;
        end else begin
            spike_prev <= spike;
            if (clear) begin
                live <= '0;
                snap <= '0;
                ovf  <= 1'b0;
            end else begin
                if (tick && !mode)
                    live <= '0;
                else
                    live <= sum;
                if (tick)
                    snap <= sum;
                // Snapshot sum overflows under the same condition as live.
                if (ovf_hit)
                    ovf <= 1'b1;
            end
        end
    end
endmodule

module spike_counter_bank #(
    parameter int NCH   = 8,
    parameter int CNT_W = 32,
    parameter int SAT   = 1,
    parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             tick,
    input  logic             clear,
    input  logic [NCH-1:0]   spike_in,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             snap_valid,
    output logic [NCH-1:0]   ovf
);
    logic [NCH-1:0][CNT_W-1:0] snap;
    logic [CNT_W-1:0]          rd_mux;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        spike_counter_lane #(
            .CNT_W (CNT_W),
            .SAT   (SAT != 0)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .mode  (mode),
            .tick  (tick),
            .clear (clear),
            .spike (spike_in[g]),
            .snap  (snap[g]),
            .ovf   (ovf[g])
        );
    end

    // Decoded mux: selects that match no channel fall through to 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_sel == SEL_W'(i))
                rd_mux = snap[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data    <= '0;
            snap_valid <= 1'b0;
        end else begin
            rd_data    <= rd_mux;
            // clear wins over a coincident tick, so no pulse then.
            snap_valid <= tick & ~clear;
        end
    end
endmodule

// File: doc/spike_counter_bank.md
# spike_counter_bank

Parametrised, multi-channel successor to the single-neuron spike counter: counts rising edges on NCH spike lines in parallel, latches per-channel counts into snapshot registers on each simulation-time tick, and serves them through a registered read port. It sits between the neuron population and the muscle/host-readout logic, feeding per-motor-unit spike counts to muscle models and OpalKelly wire-outs.

## Interface
- NCH, 8, number of spike channels (1..64)
- CNT_W, 32, counter and snapshot width in bits (8..32)
- SAT, 1, overflow mode: 1 = saturate at 2^CNT_W-1, 0 = wrap to 0
- SEL_W, $clog2(NCH) (min 1), read-select width (derived)

- clk  in  1  sole clock; all inputs synchronous to it
- reset  in  1  asynchronous, active-low; clears all state
- en  in  1  count enable; when 0 no edges are counted, ticks still snapshot
- mode  in  1  0 = windowed (live counters cleared at tick), 1 = cumulative (never cleared by tick)
- tick  in  1  one-cycle strobe marking end of a 1 ms simulation step
- clear  in  1  synchronous clear of live counters, snapshots and overflow flags
- spike_in  in  NCH  raw spike levels, one per channel
- rd_sel  in  SEL_W  snapshot channel to read
- rd_data  out  CNT_W  snapshot of channel rd_sel, registered
- snap_valid  out  1  one-cycle pulse: new snapshots visible
- ovf  out  NCH  sticky per-channel overflow flags

## Operation
- Edge detect: spike_prev[i] registered each cycle; edge[i] = spike_in[i] & ~spike_prev[i] & en. Held-high input counts once.
- Live counter update per channel, priority order:
  - clear: live <= 0.
  - tick, mode 0: live <= 0 (edge this cycle goes into the snapshot, not the new window).
  - otherwise: live <= live + edge[i] subject to overflow rule.
- Snapshot on tick (clear not asserted): snap[i] <= live[i] + edge[i], same overflow rule. No spike is lost or double-counted across a window boundary.
- Overflow: when live = 2^CNT_W-1 and edge = 1: SAT=1 holds max, SAT=0 wraps to 0; either way ovf[i] <= 1. Same rule on snapshot sum. ovf cleared only by clear or reset.
- clear with tick in same cycle: clear wins; snapshots become 0, snap_valid does not pulse.
- mode may change any cycle; takes effect on the next tick decision.
- Read: rd_data <= snap[rd_sel]; rd_sel >= NCH returns 0.

## Timing
- Reset (reset = 0, async): live, snap, spike_prev, ovf, rd_data, snap_valid all 0. Release synchronous to clk via existing top-level handling; first edge counted on first cycle after release where spike_in rises from 0 relative to spike_prev = 0 (a line already high at release counts once).
- Edge latency: spike_in rising at edge k -> live incremented at edge k.
- Tick at edge k -> snap updated and snap_valid = 1 during cycle k+1; snap_valid low at k+2 unless tick repeats.
- Read latency: 1 cycle; rd_sel sampled at edge k, rd_data valid after edge k. If snapshot updates at the same edge, rd_data shows the old snapshot; new value visible one cycle later.
- Back-to-back ticks allowed; each produces its own snapshot and snap_valid pulse.
- No combinational path from inputs to outputs.

## Test plan
- Windowed count: NCH=8, mode 0, ch3 gets 5 pulses, ch0 gets 2, then tick -> snap_valid pulse, rd_sel=3 gives 5, rd_sel=0 gives 2, others 0; second tick with no spikes -> all 0.
- Boundary edge: mode 0, 4 edges on ch1, 5th rising edge coincident with tick -> snap[1]=5, live[1]=0; next tick without spikes -> snap[1]=0.
- Cumulative: mode 1, 3 edges, tick, 4 edges, tick -> snap reads 3 then 7.
- Overflow: CNT_W=8; SAT=1, 300 edges on ch2 -> snap[2]=255, ovf[2]=1; SAT=0, 257 edges -> snap[2]=1, ovf[2]=1; clear -> ovf=0, all snaps 0.
- Held level and enable: ch4 held high 100 cycles -> count 1; en=0 during 3 pulses -> count unchanged; out-of-range rd_sel=9 (NCH=8, SEL_W=4) -> rd_data 0.
- Async reset mid-window: 6 edges counted, reset low between clock edges -> rd_data, snap_valid, ovf 0 immediately; after release, tick with no spikes -> snap 0.
